// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N-channel synchroniser, debouncer and edge detector
module input_conditioner #(
  parameter int              N_CH            = 8,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [N_CH-1:0] RESET_LEVEL     = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]   cnt    [N_CH];
  logic [N_CH-1:0] sq;

  assign sq       = sync_q[SYNC_STAGES-1];
  assign any_rise = |rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_LEVEL;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      level <= RESET_LEVEL;
      rise  <= '0;
      fall  <= '0;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < N_CH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (sq[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // Last disagreeing sample in a row: accept the new level and pulse once.
          level[i] <= sq[i];
          cnt[i]   <= '0;
          rise[i]  <= sq[i];
          fall[i]  <= ~sq[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized and directed checks against a window model
module tb_input_conditioner;
  localparam int N = 8;
  localparam int S = 2;
  localparam int DEB = 4;
  localparam logic [N-1:0] RL = '0;
  localparam int MAXT = 4096;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] din;
  logic [N-1:0] level, rise, fall;
  logic any_rise;

  input_conditioner #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .RESET_LEVEL(RL)) dut (
    .clk(clk), .reset(reset), .din(din), .level(level), .rise(rise), .fall(fall),
    .any_rise(any_rise)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int t = 0;
  int last_rst = -1000;
  logic [N-1:0] din_at [MAXT];
  logic [N-1:0] sq_at [MAXT];
  int epoch [N];
  logic [N-1:0] m_level, m_rise, m_fall;
  int ev_rise [N];
  int ev_fall [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_events();
    for (int i = 0; i < N; i++) begin
      ev_rise[i] = 0;
      ev_fall[i] = 0;
    end
  endtask

  // The synchronised sample used at edge t is din from S edges earlier, unless a
  // reset edge lies in between; a change is accepted once the last DEB samples since
  // the channel's last reset/acceptance all differ from the current level.
  task automatic step(input logic [N-1:0] d, input logic r);
    logic [N-1:0] sq;
    bit ok;
    din = d;
    reset = r;
    @(posedge clk);
    t++;
    din_at[t] = d;
    #1;
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      m_level = RL;
      last_rst = t;
      for (int i = 0; i < N; i++) epoch[i] = t + 1;
      sq_at[t] = RL;
    end else begin
      sq = (last_rst >= t - S) ? RL : din_at[t-S];
      sq_at[t] = sq;
      for (int i = 0; i < N; i++) begin
        ok = (t - DEB + 1) >= epoch[i];
        for (int k = t - DEB + 1; k <= t; k++)
          if (ok && sq_at[k][i] == m_level[i]) ok = 0;
        if (ok) begin
          m_level[i] = sq[i];
          m_rise[i] = sq[i];
          m_fall[i] = ~sq[i];
          epoch[i] = t + 1;
        end
      end
    end
    chk($sformatf("level@%0d", t), 32'(level), 32'(m_level));
    chk($sformatf("rise@%0d", t), 32'(rise), 32'(m_rise));
    chk($sformatf("fall@%0d", t), 32'(fall), 32'(m_fall));
    chk($sformatf("any_rise@%0d", t), 32'(any_rise), 32'(|m_rise));
    for (int i = 0; i < N; i++) begin
      ev_rise[i] += int'(rise[i]);
      ev_fall[i] += int'(fall[i]);
    end
  endtask

  initial begin
    logic [N-1:0] d;
    din = '1;
    reset = 1'b1;
    m_level = RL;
    for (int i = 0; i < N; i++) epoch[i] = 0;
    clear_events();

    // reset with inputs high, then release
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b0);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_rise", 32'(rise), 32'h0);
    chk("reset_fall", 32'(fall), 32'h0);
    chk("reset_any_rise", 32'(any_rise), 32'h0);
    repeat (8) step(8'h00, 1'b0);

    // single press on channel 0: accepted on the 6th edge
    for (int e = 1; e <= 5; e++) step(8'h01, 1'b0);
    chk("press_lvl_e5", 32'(level[0]), 32'h0);
    step(8'h01, 1'b0);
    chk("press_lvl_e6", 32'(level[0]), 32'h1);
    chk("press_rise_e6", 32'(rise[0]), 32'h1);
    chk("press_any_e6", 32'(any_rise), 32'h1);
    step(8'h01, 1'b0);
    chk("press_rise_e7", 32'(rise[0]), 32'h0);
    chk("press_any_e7", 32'(any_rise), 32'h0);

    // 3-cycle glitch on channel 3 is rejected
    clear_events();
    repeat (3) step(8'h09, 1'b0);
    repeat (8) step(8'h01, 1'b0);
    chk("glitch_level", 32'(level[3]), 32'h0);
    chk("glitch_rise", 32'(ev_rise[3]), 32'h0);
    chk("glitch_fall", 32'(ev_fall[3]), 32'h0);

    // bouncing channel 5 yields exactly one rise, 5 edges after the final 1 is applied
    clear_events();
    step(8'h21, 1'b0);
    step(8'h01, 1'b0);
    step(8'h21, 1'b0);
    step(8'h01, 1'b0);
    step(8'h21, 1'b0);
    for (int e = 1; e <= 4; e++) step(8'h21, 1'b0);
    chk("bounce_before", 32'(ev_rise[5]), 32'h0);
    step(8'h21, 1'b0);
    chk("bounce_rise_edge", 32'(rise[5]), 32'h1);
    repeat (6) step(8'h21, 1'b0);
    chk("bounce_rise_cnt", 32'(ev_rise[5]), 32'h1);
    chk("bounce_fall_cnt", 32'(ev_fall[5]), 32'h0);

    // simultaneous rises and falls
    repeat (10) step(8'h0F, 1'b0);
    chk("steady_0f", 32'(level), 32'h0F);
    for (int e = 1; e <= 6; e++) step(8'hF0, 1'b0);
    chk("swap_rise", 32'(rise), 32'hF0);
    chk("swap_fall", 32'(fall), 32'h0F);
    chk("swap_level", 32'(level), 32'hF0);

    // reset in the middle of a count
    repeat (10) step(8'h00, 1'b0);
    clear_events();
    for (int e = 1; e <= 3; e++) step(8'h04, 1'b0);
    step(8'h04, 1'b1);
    for (int e = 1; e <= 5; e++) step(8'h04, 1'b0);
    chk("midrst_lvl_e5", 32'(level[2]), 32'h0);
    chk("midrst_no_pulse", 32'(ev_rise[2] + ev_fall[2]), 32'h0);
    step(8'h04, 1'b0);
    chk("midrst_lvl_e6", 32'(level[2]), 32'h1);
    chk("midrst_rise_e6", 32'(rise[2]), 32'h1);

    // randomized slow-changing inputs with occasional resets
    d = 8'h04;
    repeat (2000) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
      step(d, $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
